// File: rtl/opb_register_simulink2ppc_snap_pkg.sv
// Shared definitions for the simulink-to-PPC snapshot register and its OPB ack logic.
package opb_snap_pkg;

  localparam logic [1:0] IDX_DATA   = 2'd0;
  localparam logic [1:0] IDX_STATUS = 2'd1;
  localparam logic [1:0] IDX_CTRL   = 2'd2;
  localparam logic [1:0] IDX_TSTAMP = 2'd3;

  localparam int CTRL_CLEAR_BIT  = 0;
  localparam int CTRL_FREEZE_BIT = 1;

  localparam int STATUS_VALID_BIT  = 0;
  localparam int STATUS_OVF_BIT    = 1;
  localparam int STATUS_FROZEN_BIT = 2;
  localparam int STATUS_COUNT_LSB  = 16;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } ack_state_e;

  function automatic logic [31:0] pack_status(input logic [15:0] count, input logic frozen,
                                              input logic overflow, input logic valid);
    return {count, 13'b0, frozen, overflow, valid};
  endfunction

endpackage

// File: rtl/opb_register_simulink2ppc_snap_if.sv
// OPB slave-side bus bundle (big-endian bit numbering as on the OPB segment).
interface opb_snap_if;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );
endinterface

// File: rtl/opb_register_simulink2ppc_snap_ack_fsm.sv
// Address-window decode and single-cycle OPB transfer acknowledge.
//   state | meaning
//   IDLE  | waiting for select inside the window; accept pulses on the hit
//   ACK   | xferAck high for this one cycle; select is ignored here
module opb_slave_ack_fsm
  import opb_snap_pkg::*;
#(
  parameter logic [31:0] BASEADDR = 32'h0100E400,
  parameter logic [31:0] HIGHADDR = 32'h0100E4FF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        select,
  input  logic [31:0] addr,
  output logic        accept,
  output logic        ack,
  output logic [1:0]  idx
);

  ack_state_e state;
  logic       hit;

  assign hit    = select && (addr >= BASEADDR) && (addr <= HIGHADDR);
  assign accept = (state == IDLE) && hit;
  assign idx    = addr[3:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ack   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            state <= ACK;
            ack   <= 1'b1;
          end
        end
        ACK: begin
          state <= IDLE;
          ack   <= 1'b0;
        end
        default: begin
          state <= IDLE;
          ack   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/opb_register_simulink2ppc_snap.sv
// Fabric-to-PPC snapshot register on OPB: held data, sticky flags, update counter, freeze.
// Optional capture timestamp at index 3 when OPB_SNAP_TIMESTAMP_EN is defined.
module opb_register_simulink2ppc_snap
  import opb_snap_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0100E400,
  parameter logic [31:0] C_HIGHADDR   = 32'h0100E4FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter              C_FAMILY     = "virtex6"
) (
  input  logic        OPB_Clk,
  input  logic        OPB_Rst_n,
  opb_snap_if.slave   bus,
  input  logic [31:0] user_data_in,
  input  logic        user_valid,
  output logic        user_frozen
);

  logic [31:0] addr, wdata, rd_mux, rd_q, snap_data, tstamp;
  logic [15:0] count;
  logic [1:0]  idx;
  logic        accept, ack, valid, overflow, frozen;
  logic        rd_en, wr_ctrl, clear, rd_data, capture;
  logic        unused_ok;

  assign addr  = bus.OPB_ABus;
  assign wdata = bus.OPB_DBus;

  opb_slave_ack_fsm #(
    .BASEADDR (C_BASEADDR),
    .HIGHADDR (C_HIGHADDR)
  ) u_ack_fsm (
    .clk    (OPB_Clk),
    .rst_n  (OPB_Rst_n),
    .select (bus.OPB_select),
    .addr   (addr),
    .accept (accept),
    .ack    (ack),
    .idx    (idx)
  );

  assign rd_en   = accept && bus.OPB_RNW;
  assign wr_ctrl = accept && !bus.OPB_RNW && bus.OPB_BE[3] && (idx == IDX_CTRL);
  assign clear   = wr_ctrl && wdata[CTRL_CLEAR_BIT];
  assign rd_data = rd_en && (idx == IDX_DATA);
  assign capture = user_valid && !frozen;

  always_comb begin
    rd_mux = 32'h0;
    case (idx)
      IDX_DATA:   rd_mux = snap_data;
      IDX_STATUS: rd_mux = pack_status(count, frozen, overflow, valid);
      IDX_CTRL:   rd_mux[CTRL_FREEZE_BIT] = frozen;
      IDX_TSTAMP: rd_mux = tstamp;
      default:    rd_mux = 32'h0;
    endcase
  end

  // CLEAR is applied before the capture increment; a same-cycle DATA read consumes the old valid.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      snap_data <= 32'h0;
      valid     <= 1'b0;
      overflow  <= 1'b0;
      frozen    <= 1'b0;
      count     <= 16'h0;
      rd_q      <= 32'h0;
    end else begin
      if (accept) rd_q <= rd_en ? rd_mux : 32'h0;
      if (wr_ctrl) frozen <= wdata[CTRL_FREEZE_BIT];

      if (capture) begin
        snap_data <= user_data_in;
        valid     <= 1'b1;
        count     <= (clear ? 16'h0 : count) + 16'h1;
      end else begin
        if (rd_data) valid <= 1'b0;
        if (clear)   count <= 16'h0;
      end

      if (clear) overflow <= 1'b0;
      else if (capture && valid && !rd_data) overflow <= 1'b1;
    end
  end

`ifdef OPB_SNAP_TIMESTAMP_EN
  logic [31:0] cyc_cnt;

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      cyc_cnt <= 32'h0;
      tstamp  <= 32'h0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'h1;
      if (capture) tstamp <= cyc_cnt;
    end
  end
`else
  assign tstamp = 32'h0;
`endif

  assign bus.Sl_DBus    = ack ? rd_q : 32'h0;
  assign bus.Sl_xferAck = ack;
  assign bus.Sl_errAck  = 1'b0;
  assign bus.Sl_retry   = 1'b0;
  assign bus.Sl_toutSup = 1'b0;
  assign user_frozen    = frozen;

  assign unused_ok = ^{wdata[31:2], bus.OPB_BE[0:2], bus.OPB_seqAddr, C_FAMILY,
                       C_OPB_AWIDTH, C_OPB_DWIDTH};

endmodule

// File: tb/tb_opb_register_simulink2ppc_snap.sv
// Bench for opb_register_simulink2ppc_snap: transaction-level model plus directed reads/writes.
module tb_opb_register_simulink2ppc_snap;

  localparam logic [31:0] BASE = 32'h0100E400;
  localparam logic [31:0] HIGH = 32'h0100E4FF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] user_data_in = 32'h0;
  logic        user_valid = 1'b0;
  logic        user_frozen;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  opb_snap_if bus ();

  opb_register_simulink2ppc_snap #(
    .C_BASEADDR   (BASE),
    .C_HIGHADDR   (HIGH),
    .C_OPB_AWIDTH (32),
    .C_OPB_DWIDTH (32),
    .C_FAMILY     ("virtex6")
  ) dut (
    .OPB_Clk      (clk),
    .OPB_Rst_n    (rst_n),
    .bus          (bus),
    .user_data_in (user_data_in),
    .user_valid   (user_valid),
    .user_frozen  (user_frozen)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Register-level model of the slave: what a master and the fabric should observe.
  logic [31:0] m_data, m_ts, m_cyc, m_dbus, a;
  logic [15:0] m_cnt;
  logic        m_valid, m_ovf, m_frozen, m_ack;
  logic        t_acc, t_rd, t_wr, t_cap, t_clr, t_rdd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data = 0; m_ts = 0; m_cyc = 0; m_dbus = 0; m_cnt = 0;
      m_valid = 0; m_ovf = 0; m_frozen = 0; m_ack = 0;
    end else begin
      a     = bus.OPB_ABus;
      t_acc = bus.OPB_select && a >= BASE && a <= HIGH && !m_ack;
      t_rd  = t_acc && bus.OPB_RNW;
      t_wr  = t_acc && !bus.OPB_RNW && bus.OPB_BE[3] && a[3:2] == 2'd2;
      t_clr = t_wr && bus.OPB_DBus[31];
      t_rdd = t_rd && a[3:2] == 2'd0;
      t_cap = user_valid && !m_frozen;
      if (t_acc) begin
        m_dbus = 0;
        if (t_rd) begin
          case (a[3:2])
            2'd0: m_dbus = m_data;
            2'd1: m_dbus = (32'(m_cnt) << 16) | (m_frozen ? 4 : 0) | (m_ovf ? 2 : 0) | (m_valid ? 1 : 0);
            2'd2: m_dbus = m_frozen ? 2 : 0;
`ifdef OPB_SNAP_TIMESTAMP_EN
            default: m_dbus = m_ts;
`else
            default: m_dbus = 0;
`endif
          endcase
        end
      end
      m_ack = t_acc;
      if (t_clr) begin m_cnt = 0; m_ovf = 0; end
      if (t_cap) begin
        if (m_valid && !t_rdd && !t_clr) m_ovf = 1;
        m_data = user_data_in; m_valid = 1; m_cnt = m_cnt + 1; m_ts = m_cyc;
      end else if (t_rdd) m_valid = 0;
      if (t_wr) m_frozen = bus.OPB_DBus[30];
      m_cyc = m_cyc + 1;
    end
  end

  always @(negedge clk) begin
    chk("ack_model", 32'(bus.Sl_xferAck), 32'(m_ack));
    chk("dbus_model", bus.Sl_DBus, m_ack ? m_dbus : 32'h0);
    chk("frozen_model", 32'(user_frozen), 32'(m_frozen));
    chk("tied_zero", {29'h0, bus.Sl_errAck, bus.Sl_retry, bus.Sl_toutSup}, 32'h0);
  end

  task automatic xfer(input logic [31:0] addr, input logic rnw, input logic [31:0] wd,
                      input logic [3:0] be, input logic strobe, input logic [31:0] sd,
                      output logic [31:0] rd);
    int n;
    bus.OPB_ABus = addr; bus.OPB_RNW = rnw; bus.OPB_DBus = wd; bus.OPB_BE = be;
    bus.OPB_select = 1'b1;
    if (strobe) begin user_valid = 1'b1; user_data_in = sd; end
    @(negedge clk);
    user_valid = 1'b0;
    n = 1;
    while (!bus.Sl_xferAck && n < 4) begin @(negedge clk); n++; end
    rd = bus.Sl_DBus;
    bus.OPB_select = 1'b0;
    chk("ack_latency", 32'(n), 32'd1);
    @(negedge clk);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] off, input logic [31:0] exp);
    logic [31:0] r;
    xfer(BASE + off, 1'b1, 32'h0, 4'hF, 1'b0, 32'h0, r);
    chk(name, r, exp);
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r;
    xfer(BASE + off, 1'b0, wd, be, 1'b0, 32'h0, r);
  endtask

  task automatic strobe(input logic [31:0] d);
    user_valid = 1'b1; user_data_in = d;
    @(negedge clk);
    user_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    int seen;
    bus.OPB_ABus = 0; bus.OPB_BE = 0; bus.OPB_DBus = 0; bus.OPB_RNW = 0;
    bus.OPB_select = 0; bus.OPB_seqAddr = 0;
    repeat (3) @(negedge clk);
    chk("reset_ack", 32'(bus.Sl_xferAck), 32'h0);
    chk("reset_frozen", 32'(user_frozen), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    rd_chk("status_after_reset", 32'h4, 32'h00000000);
    strobe(32'hDEADBEEF);
    rd_chk("data_deadbeef", 32'h0, 32'hDEADBEEF);
    rd_chk("status_cnt1", 32'h4, 32'h00010000);

    wr(32'h8, 32'h1, 4'hF);
    strobe(32'h11);
    strobe(32'h22);
    rd_chk("status_ovf", 32'h4, 32'h00020003);
    wr(32'h8, 32'h1, 4'hF);
    rd_chk("status_cleared", 32'h4, 32'h00000001);
    rd_chk("data_22", 32'h0, 32'h00000022);

    wr(32'h8, 32'h2, 4'hF);
    chk("user_frozen_on", 32'(user_frozen), 32'h1);
    strobe(32'h55);
    rd_chk("status_frozen", 32'h4, 32'h00000004);
    rd_chk("data_held", 32'h0, 32'h00000022);
    rd_chk("ctrl_readback", 32'h8, 32'h00000002);
    wr(32'h8, 32'h0, 4'hF);
    chk("user_frozen_off", 32'(user_frozen), 32'h0);
    strobe(32'h66);
    rd_chk("status_unfrozen", 32'h4, 32'h00010001);

    xfer(BASE, 1'b1, 32'h0, 4'hF, 1'b1, 32'h77, r);
    chk("same_cycle_old_data", r, 32'h00000066);
    rd_chk("status_same_cycle", 32'h4, 32'h00020001);
    rd_chk("data_77", 32'h0, 32'h00000077);

`ifdef OPB_SNAP_TIMESTAMP_EN
    rd_chk("tstamp", 32'hC, m_ts);
`else
    rd_chk("tstamp_off", 32'hC, 32'h00000000);
`endif

    strobe(32'h88);
    xfer(BASE + 32'h8, 1'b0, 32'h1, 4'hF, 1'b1, 32'h99, r);
    rd_chk("status_clear_capture", 32'h4, 32'h00010001);
    rd_chk("data_99", 32'h0, 32'h00000099);

    wr(32'h8, 32'h2, 4'b1110);
    chk("be3_low_ignored", 32'(user_frozen), 32'h0);
    wr(32'h0, 32'h12345678, 4'hF);
    rd_chk("ro_write_discarded", 32'h0, 32'h00000099);

    bus.OPB_ABus = HIGH + 32'h1; bus.OPB_RNW = 1'b1; bus.OPB_select = 1'b1;
    seen = 0;
    repeat (4) begin @(negedge clk); if (bus.Sl_xferAck) seen++; end
    bus.OPB_select = 1'b0;
    chk("out_of_window_no_ack", 32'(seen), 32'h0);

    bus.OPB_ABus = BASE + 32'h4; bus.OPB_select = 1'b1;
    seen = 0;
    repeat (4) begin @(negedge clk); if (bus.Sl_xferAck) seen++; end
    bus.OPB_select = 1'b0;
    chk("held_select_two_acks", 32'(seen), 32'h2);
    @(negedge clk);

    bus.OPB_ABus = BASE + 32'h4; bus.OPB_select = 1'b1;
    @(negedge clk);
    chk("ack_before_reset", 32'(bus.Sl_xferAck), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("ack_aborted", 32'(bus.Sl_xferAck), 32'h0);
    chk("dbus_aborted", bus.Sl_DBus, 32'h0);
    bus.OPB_select = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd_chk("status_after_reset2", 32'h4, 32'h00000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
